cdc_fifo_write_arbiter: RTL and testbench
=========================================

CDC_FIFO_WRITE_ARBITER -- requirements
Module: cdc_fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning FIFO word width.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning maximum beats per grant (1..16).
REQ-004 SHALL have port clock, input, 1, meaning sole clock (FIFO write domain).
REQ-005 SHALL have port reset_n, input, 1, meaning reset; synchronous, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning per-requester word available.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, meaning requester i word at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready, output, NUM_REQ, meaning per-requester word accepted this cycle when valid.
REQ-009 SHALL have port fifo_full, input, 1, meaning FIFO write-side full flag.
REQ-010 SHALL have port fifo_write, output, 1, meaning write strobe to FIFO memory and write-pointer increment.
REQ-011 SHALL have port fifo_write_data, output, DATA_WIDTH, meaning word written.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ), meaning current/last granted requester.
REQ-013 SHALL have port busy, output, 1, meaning state is GRANT.

Function
REQ-014 SHALL implement two states: IDLE and GRANT.
REQ-015 SHALL, in IDLE with any req_valid high, select the first valid requester searching upward from grant_id+1 (mod NUM_REQ), register it into grant_id, clear the beat counter, and enter GRANT next cycle.
REQ-016 SHALL remain in IDLE while no req_valid is high; grant_id holds.
REQ-017 SHALL, in GRANT, drive req_ready[grant_id] = !fifo_full combinationally; all other req_ready bits 0.
REQ-018 SHALL assert fifo_write = busy & req_valid[grant_id] & !fifo_full, same cycle, with fifo_write_data = req_data slice of grant_id (zero-latency mux).
REQ-019 SHALL never assert fifo_write while fifo_full is high.
REQ-020 SHALL increment the beat counter only on fifo_write cycles.
REQ-021 SHALL return to IDLE after the cycle in which beat BURST_LEN is written.
REQ-022 SHALL return to IDLE after any GRANT cycle with req_valid[grant_id] low.
REQ-023 SHALL hold the grant and beat count while fifo_full stalls with req_valid high; other requesters wait.
REQ-024 SHALL drive fifo_write_data to 0 when fifo_write is low.
REQ-025 SHALL cost exactly one IDLE cycle between consecutive grants, including re-grant to the same sole requester.

Reset
REQ-026 SHALL, on a clock edge with reset_n low, enter IDLE, set grant_id to NUM_REQ-1 (requester 0 wins first), clear beat counter and stall counter.
REQ-027 SHALL hold fifo_write, req_ready and busy at 0 during any reset cycle; reset mid-burst abandons the burst with no partial write.

Configuration
REQ-028 SHALL, with CDC_FIFO_ARB_STATS_EN defined, add output stall_count (8 bits): saturating count of GRANT cycles with req_valid[grant_id] & fifo_full, cleared by reset, held at 255.
REQ-029 SHALL, without CDC_FIFO_ARB_STATS_EN, omit the stall_count port and its logic entirely.

Structure
REQ-030 SHALL take the state enum typedef (arb_state_t) and STALL_COUNT_WIDTH = 8 from shared package cdc_fifo_pkg.
REQ-031 SHALL place rotating-priority selection in one combinational sub-module cdc_fifo_rr_pick (inputs request vector, last grant; outputs index and any-valid).

Verification
REQ-032 SHALL cover: reset, req_valid=4'b0101 held -> first grant_id=0, 4 writes, one IDLE cycle, then grant_id=2.
REQ-033 SHALL cover: only requester 3 valid for 10 words -> writes in groups 4,4,2 separated by single IDLE cycles; grant_id=3 throughout.
REQ-034 SHALL cover: fifo_full high 3 cycles after beat 2 of a burst -> fifo_write and req_ready low for those 3 cycles, beats 3-4 written afterwards, no data lost or duplicated.
REQ-035 SHALL cover: requester 1 drops valid after beat 1 while requester 2 valid -> IDLE next cycle, then grant_id=2.
REQ-036 SHALL cover: reset_n low at beat 2 of a burst -> fifo_write 0 that cycle, after release grant_id=0 if requester 0 valid.
REQ-037 SHALL cover (CDC_FIFO_ARB_STATS_EN): 300 stalled cycles -> stall_count=255; without macro, build has no stall_count port.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the CDC FIFO write arbiter.
package cdc_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned STALL_COUNT_WIDTH = 8;

endpackage

// File: rtl/cdc_fifo_rr_pick.sv
// Rotating-priority picker: the first set request bit searching upward from last_i+1 (mod NUM_REQ).
module cdc_fifo_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        idx_o = last_i;
        any_o = 1'b0;
        // Offset k = NUM_REQ wraps back onto last_i, so a sole requester can win again.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!any_o && req_vec_i[IDX_W'(cand)]) begin
                idx_o = IDX_W'(cand);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter feeding the write side of a CDC FIFO.
// Define CDC_FIFO_ARB_STATS_EN to add the saturating stall_count output.
module cdc_fifo_write_arbiter
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef CDC_FIFO_ARB_STATS_EN
    ,
    output logic [STALL_COUNT_WIDTH-1:0]  stall_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  active;
    logic                  cur_valid;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    cdc_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_vec_i (req_valid),
        .last_i    (grant_q),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    // Gating with reset_n keeps every strobe low in a reset cycle, even mid-burst.
    assign active     = (state_q == GRANT) && reset_n;
    assign cur_valid  = req_valid[grant_q];
    assign fifo_write = active && cur_valid && !fifo_full;
    assign busy       = active;
    assign grant_id   = grant_q;

    always_comb begin
        req_ready       = '0;
        fifo_write_data = '0;
        if (active && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
        if (fifo_write) begin
            fifo_write_data = words[grant_q];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!cur_valid) begin
                    state_d = IDLE;
                end else if (fifo_write) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

`ifdef CDC_FIFO_ARB_STATS_EN
    logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (active && cur_valid && fifo_full && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Self-checking bench for cdc_fifo_write_arbiter; stall_count checks build when CDC_FIFO_ARB_STATS_EN is defined.
module tb_cdc_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_write;
    logic [DW-1:0]   fifo_write_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef CDC_FIFO_ARB_STATS_EN
    logic [7:0]      stall_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the FIFO, whether a burst is open, beats written so far.
    int m_owner = N - 1;
    bit m_busy  = 1'b0;
    int m_beats = 0;

    bit log_w[$];
    bit log_b[$];
    bit log_r[$];
    int log_g[$];
    int log_d[$];

    cdc_fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clock           (clk),
        .reset_n         (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_write_data (fifo_write_data),
        .grant_id        (grant_id),
        .busy            (busy)
`ifdef CDC_FIFO_ARB_STATS_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit bit_of(logic [N-1:0] v, int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [DW-1:0] word_of(int i);
        return DW'(req_data >> (i * DW));
    endfunction

    function automatic int rr_next(int owner, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (bit_of(v, (owner + k) % N)) return (owner + k) % N;
        end
        return owner;
    endfunction

    task automatic clear_log();
        log_w.delete(); log_b.delete(); log_r.delete(); log_g.delete(); log_d.delete();
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_d;
        logic          exp_w;
        logic          exp_b;
        int            exp_g;
        @(negedge clk);
        exp_g     = m_owner;
        exp_ready = '0;
        exp_d     = '0;
        exp_w     = 1'b0;
        exp_b     = 1'b0;
        if (rst_n && m_busy) begin
            exp_b = 1'b1;
            exp_w = bit_of(req_valid, m_owner) && !fifo_full;
            if (!fifo_full) exp_ready = N'(1) << m_owner;
            if (exp_w) exp_d = word_of(m_owner);
        end
        checks++;
        if (busy !== exp_b) begin
            errors++; $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy, exp_b);
        end
        checks++;
        if (fifo_write !== exp_w) begin
            errors++; $display("FAIL model_write t=%0t: got %b expected %b", $time, fifo_write, exp_w);
        end
        checks++;
        if (req_ready !== exp_ready) begin
            errors++; $display("FAIL model_ready t=%0t: got %b expected %b", $time, req_ready, exp_ready);
        end
        checks++;
        if (fifo_write_data !== exp_d) begin
            errors++; $display("FAIL model_data t=%0t: got %h expected %h", $time, fifo_write_data, exp_d);
        end
        checks++;
        if (grant_id !== 2'(exp_g)) begin
            errors++; $display("FAIL model_grant t=%0t: got %0d expected %0d", $time, grant_id, exp_g);
        end
        log_w.push_back(fifo_write);
        log_b.push_back(busy);
        log_r.push_back(req_ready != '0);
        log_g.push_back(int'(grant_id));
        log_d.push_back(int'(fifo_write_data));

        if (!rst_n) begin
            m_owner = N - 1; m_busy = 1'b0; m_beats = 0;
        end else if (!m_busy) begin
            if (req_valid != '0) begin
                m_owner = rr_next(m_owner, req_valid); m_beats = 0; m_busy = 1'b1;
            end
        end else if (!bit_of(req_valid, m_owner)) begin
            m_busy = 1'b0;
        end else if (exp_w) begin
            m_beats++;
            if (m_beats == BL) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        cycle();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; fifo_full = 1'b0; req_data = 32'hA1B2C3D4;
        clear_log();
        cycle(); cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_w[i] !== 1'b0 || log_b[i] !== 1'b0 || log_r[i] !== 1'b0) begin
                errors++; $display("FAIL reset_outputs: got w=%b b=%b r=%b expected 0 0 0", log_w[i], log_b[i], log_r[i]);
            end
        end
        checks++;
        if (log_g[1] != N - 1) begin
            errors++; $display("FAIL reset_grant: got %0d expected %0d", log_g[1], N - 1);
        end
        rst_n = 1'b1; req_valid = '0;
        clear_log();
        cycle(); cycle();
        checks++;
        if (log_b[1] !== 1'b0 || log_g[1] != N - 1) begin
            errors++; $display("FAIL idle_hold: got busy=%b grant=%0d expected busy=0 grant=%0d", log_b[1], log_g[1], N - 1);
        end
    endtask

    task automatic test_two_req();
        bit exp_w[12] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int exp_g[12] = '{3, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 0};
        do_reset();
        req_valid = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            req_data = $urandom;
            cycle();
        end
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (log_w[c] !== exp_w[c] || log_g[c] != exp_g[c]) begin
                errors++; $display("FAIL two_req c%0d: got w=%b g=%0d expected w=%b g=%0d", c, log_w[c], log_g[c], exp_w[c], exp_g[c]);
            end
        end
    endtask

    task automatic test_sole();
        bit exp_w[15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        int idx = 0;
        int nw  = 0;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            req_valid = (idx < 10) ? 4'b1000 : 4'b0000;
            req_data  = {8'(8'h40 + idx), 24'h0};
            cycle();
            if (log_w[c]) idx++;
        end
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (log_w[c] !== exp_w[c] || log_g[c] != 3) begin
                errors++; $display("FAIL sole c%0d: got w=%b g=%0d expected w=%b g=3", c, log_w[c], log_g[c], exp_w[c]);
            end
            if (log_w[c]) begin
                checks++;
                if (log_d[c] != 8'h40 + nw) begin
                    errors++; $display("FAIL sole_data: got %h expected %h", log_d[c], 8'h40 + nw);
                end
                nw++;
            end
        end
        checks++;
        if (nw != 10) begin
            errors++; $display("FAIL sole_count: got %0d expected 10", nw);
        end
    endtask

    task automatic test_full_stall();
        int idx = 0;
        int stall_left = 3;
        int nw = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 4) ? 4'b0001 : 4'b0000;
            req_data  = {24'h0, 8'(8'h10 + idx)};
            fifo_full = (idx == 2 && stall_left > 0);
            if (fifo_full) stall_left--;
            cycle();
            if (log_w[c]) idx++;
        end
        fifo_full = 1'b0;
        for (int c = 3; c < 6; c++) begin
            checks++;
            if (log_w[c] !== 1'b0 || log_r[c] !== 1'b0 || log_b[c] !== 1'b1) begin
                errors++; $display("FAIL stall c%0d: got w=%b r=%b b=%b expected 0 0 1", c, log_w[c], log_r[c], log_b[c]);
            end
        end
        for (int c = 0; c < 12; c++) begin
            if (log_w[c]) begin
                checks++;
                if (log_d[c] != 8'h10 + nw || log_g[c] != 0) begin
                    errors++; $display("FAIL stall_data: got %h g=%0d expected %h g=0", log_d[c], log_g[c], 8'h10 + nw);
                end
                nw++;
            end
        end
        checks++;
        if (nw != 4 || log_w[6] !== 1'b1 || log_w[7] !== 1'b1) begin
            errors++; $display("FAIL stall_resume: got writes=%0d w6=%b w7=%b expected 4 1 1", nw, log_w[6], log_w[7]);
        end
    endtask

    task automatic test_drop();
        bit exp_w[5] = '{0, 1, 0, 0, 1};
        logic [N-1:0] vseq[5] = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = vseq[c];
            req_data  = $urandom;
            cycle();
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (log_w[c] !== exp_w[c]) begin
                errors++; $display("FAIL drop_write c%0d: got %b expected %b", c, log_w[c], exp_w[c]);
            end
        end
        checks++;
        if (log_g[1] != 1 || log_b[3] !== 1'b0 || log_g[4] != 2) begin
            errors++; $display("FAIL drop_regrant: got g1=%0d b3=%b g4=%0d expected 1 0 2", log_g[1], log_b[3], log_g[4]);
        end
    endtask

    task automatic test_reset_mid();
        bit exp_w[5] = '{0, 1, 0, 0, 1};
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            rst_n    = (c != 2);
            req_data = $urandom;
            cycle();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (log_w[c] !== exp_w[c]) begin
                errors++; $display("FAIL rstmid_write c%0d: got %b expected %b", c, log_w[c], exp_w[c]);
            end
        end
        checks++;
        if (log_b[2] !== 1'b0 || log_r[2] !== 1'b0 || log_g[3] != 3 || log_g[4] != 0) begin
            errors++; $display("FAIL rstmid_state: got b2=%b r2=%b g3=%0d g4=%0d expected 0 0 3 0", log_b[2], log_r[2], log_g[3], log_g[4]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = N'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
            cycle();
        end
        rst_n = 1'b1;
    endtask

`ifdef CDC_FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (stall_count !== 8'd0) begin
            errors++; $display("FAIL stats_reset: got %0d expected 0", stall_count);
        end
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        repeat (302) cycle();
        checks++;
        if (stall_count !== 8'd255) begin
            errors++; $display("FAIL stats_saturate: got %0d expected 255", stall_count);
        end
        fifo_full = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        test_reset();
        test_two_req();
        test_sole();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_random();
`ifdef CDC_FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
